// File: rtl/sistema_pkg.sv
// Shared constants, FSM state encoding and hash payload type for the
// micro-UCR-hash nonce miner.
package sistema_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned PAYLOAD_W     = 96;
    localparam int unsigned PAYLOAD_BYTES = 12;
    localparam int unsigned NONCE_W       = 32;
    localparam int unsigned HASH_W        = 24;
    localparam int unsigned WIN_LEN       = 16;
    localparam int unsigned RND_W         = 5;

    localparam int unsigned ROUND_SPLIT   = 17;
    localparam int unsigned NUM_ROUNDS    = 32;

    localparam logic [BYTE_W-1:0] H_INIT0 = 8'h01;
    localparam logic [BYTE_W-1:0] H_INIT1 = 8'h89;
    localparam logic [BYTE_W-1:0] H_INIT2 = 8'hFE;
    localparam logic [BYTE_W-1:0] K_LO    = 8'h99;
    localparam logic [BYTE_W-1:0] K_HI    = 8'hA1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    // {H0,H1,H2}, H0 in the most significant byte
    typedef struct packed {
        logic [BYTE_W-1:0] h0;
        logic [BYTE_W-1:0] h1;
        logic [BYTE_W-1:0] h2;
    } hash_t;

endpackage

// File: rtl/micro_hash_round.sv
// One combinational round of the micro-UCR-hash plus the message expansion
// byte that enters the sliding window behind it.
//   a, b, c          current round state
//   w                message byte W[i] for this round (window head)
//   w_m3/w_m9/w_m14  window taps W[i+13], W[i+7], W[i+2]
//   rnd              round index 0..31
//   a_n, b_n, c_n    next round state
//   w_n              expanded byte W[i+16]
module micro_hash_round
    import sistema_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic [BYTE_W-1:0] c,
    input  logic [BYTE_W-1:0] w,
    input  logic [BYTE_W-1:0] w_m3,
    input  logic [BYTE_W-1:0] w_m9,
    input  logic [BYTE_W-1:0] w_m14,
    input  logic [RND_W-1:0]  rnd,
    output logic [BYTE_W-1:0] a_n,
    output logic [BYTE_W-1:0] b_n,
    output logic [BYTE_W-1:0] c_n,
    output logic [BYTE_W-1:0] w_n
);

    logic              first_half;
    logic [BYTE_W-1:0] x;
    logic [BYTE_W-1:0] k;

    // Round constant and mixing function switch at ROUND_SPLIT
    always_comb begin
        first_half = (rnd < RND_W'(ROUND_SPLIT));
        x          = first_half ? (a ^ b) : (a | b);
        k          = first_half ? K_LO : K_HI;
        a_n        = b;
        b_n        = c ^ x;
        c_n        = x + k + w;
        w_n        = w_m3 | (w_m9 ^ w_m14);
    end

endmodule

// File: rtl/sistema_area.sv
// Area-optimised nonce miner: appends a 32-bit nonce to a latched 96-bit
// payload, hashes it with one shared round unit (one round per clock) and
// steps the nonce from 0 until H0 and H1 are both below the latched target.
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   payload    message bytes W0..W11, W0 = payload[95:88]
//   active     level enable: 1 = search/hold, 0 = abort to idle
//   target     difficulty threshold
//   terminado  valid nonce found, outputs stable
//   nonceOut   winning nonce; current nonce while searching
//   hashOut    {H0,H1,H2} of the last completed hash
module sistema_area
    import sistema_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic                 active,
    input  logic [BYTE_W-1:0]    target,
    output logic                 terminado,
    output logic [NONCE_W-1:0]   nonceOut,
    output logic [HASH_W-1:0]    hashOut
);

    state_t               state_q, state_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [BYTE_W-1:0]    target_q, target_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [BYTE_W-1:0]    win_q [WIN_LEN];
    logic [BYTE_W-1:0]    win_d [WIN_LEN];
    logic [BYTE_W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
    logic [RND_W-1:0]     rnd_q, rnd_d;
    logic                 term_q, term_d;
    logic [NONCE_W-1:0]   nonce_out_q, nonce_out_d;
    hash_t                hash_q, hash_d;

    logic [BYTE_W-1:0]    ra, rb, rc, rw;
    hash_t                hash_c;
    logic                 valid_c;

    micro_hash_round u_round (
        .a     (a_q),
        .b     (b_q),
        .c     (c_q),
        .w     (win_q[0]),
        .w_m3  (win_q[13]),
        .w_m9  (win_q[7]),
        .w_m14 (win_q[2]),
        .rnd   (rnd_q),
        .a_n   (ra),
        .b_n   (rb),
        .c_n   (rc),
        .w_n   (rw)
    );

    // Final hash and difficulty test on the post-round state
    always_comb begin
        hash_c.h0 = H_INIT0 + a_q;
        hash_c.h1 = H_INIT1 + b_q;
        hash_c.h2 = H_INIT2 + c_q;
        valid_c   = (hash_c.h0 < target_q) && (hash_c.h1 < target_q);
    end

    // Next-state and datapath update; everything holds unless a state acts
    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        win_d       = win_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        rnd_d       = rnd_q;
        term_d      = term_q;
        nonce_out_d = nonce_out_q;
        hash_d      = hash_q;

        if (!active) begin
            // Abort from any state; nonceOut/hashOut keep their values
            state_d = IDLE;
            term_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    payload_d   = payload;
                    target_d    = target;
                    nonce_d     = '0;
                    nonce_out_d = '0;
                    state_d     = LOAD;
                end
                LOAD: begin
                    for (int j = 0; j < int'(PAYLOAD_BYTES); j++) begin
                        win_d[j] = payload_q[int'(PAYLOAD_W) - 1 - int'(BYTE_W) * j -: BYTE_W];
                    end
                    win_d[12] = nonce_q[31:24];
                    win_d[13] = nonce_q[23:16];
                    win_d[14] = nonce_q[15:8];
                    win_d[15] = nonce_q[7:0];
                    a_d       = H_INIT0;
                    b_d       = H_INIT1;
                    c_d       = H_INIT2;
                    rnd_d     = '0;
                    state_d   = ROUND;
                end
                ROUND: begin
                    a_d = ra;
                    b_d = rb;
                    c_d = rc;
                    // Window slides one byte; the expanded byte enters at the tail
                    for (int j = 0; j < int'(WIN_LEN) - 1; j++) begin
                        win_d[j] = win_q[j + 1];
                    end
                    win_d[WIN_LEN - 1] = rw;
                    rnd_d = rnd_q + RND_W'(1);
                    if (rnd_q == RND_W'(NUM_ROUNDS - 1)) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    hash_d = hash_c;
                    if (valid_c) begin
                        nonce_out_d = nonce_q;
                        term_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        // Wraps naturally past 0xFFFFFFFF
                        nonce_d     = nonce_q + NONCE_W'(1);
                        nonce_out_d = nonce_q + NONCE_W'(1);
                        state_d     = LOAD;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            payload_q   <= '0;
            target_q    <= '0;
            nonce_q     <= '0;
            win_q       <= '{default: '0};
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            rnd_q       <= '0;
            term_q      <= 1'b0;
            nonce_out_q <= '0;
            hash_q      <= '0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            target_q    <= target_d;
            nonce_q     <= nonce_d;
            win_q       <= win_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            rnd_q       <= rnd_d;
            term_q      <= term_d;
            nonce_out_q <= nonce_out_d;
            hash_q      <= hash_d;
        end
    end

    assign terminado = term_q;
    assign nonceOut  = nonce_out_q;
    assign hashOut   = hash_q;

endmodule

// File: tb/tb_sistema_area.sv
// Directed bench for sistema_area: reset, easy/golden searches, abort and
// restart, input latching and an unreachable target.
module tb_sistema_area;

    localparam logic [95:0] GOLD_P = 96'h397d9f2f40ca9e6c6b1f3324;
    localparam logic [95:0] P2     = 96'h0123456789abcdef00112233;
    localparam logic [95:0] P3     = 96'hdeadbeefcafef00d12345678;

    logic        clk;
    logic        reset_n;
    logic [95:0] payload;
    logic        active;
    logic [7:0]  target;
    logic        terminado;
    logic [31:0] nonceOut;
    logic [23:0] hashOut;

    int checks;
    int failures;

    sistema_area dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .payload   (payload),
        .active    (active),
        .target    (target),
        .terminado (terminado),
        .nonceOut  (nonceOut),
        .hashOut   (hashOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference hash built from the full 32-byte expanded message
    function automatic logic [23:0] model_hash(input logic [95:0] p, input logic [31:0] n);
        logic [7:0]   w [32];
        logic [127:0] msg;
        logic [7:0]   a, b, c, x, k, cn, h0, h1, h2;
        msg = {p, n};
        for (int i = 0; i < 16; i++) w[i] = msg[127 - 8 * i -: 8];
        for (int i = 16; i < 32; i++) w[i] = w[i - 3] | (w[i - 9] ^ w[i - 14]);
        a = 8'h01;
        b = 8'h89;
        c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            if (i < 17) begin
                k = 8'h99;
                x = a ^ b;
            end else begin
                k = 8'hA1;
                x = a | b;
            end
            cn = x + k + w[i];
            a  = b;
            b  = c ^ x;
            c  = cn;
        end
        h0 = 8'h01 + a;
        h1 = 8'h89 + b;
        h2 = 8'hFE + c;
        return {h0, h1, h2};
    endfunction

    function automatic int unsigned find_nonce(input logic [95:0] p, input logic [7:0] t,
                                               input int unsigned limit);
        logic [23:0] h;
        for (int unsigned n = 0; n < limit; n++) begin
            h = model_hash(p, n);
            if ((h[23:16] < t) && (h[15:8] < t)) return n;
        end
        return limit;
    endfunction

    // Full search from idle; optionally disturbs payload/target after the latch
    task automatic run_search(input string tag, input logic [95:0] p, input logic [7:0] t,
                              input int unsigned limit, input bit scramble);
        int unsigned n_exp;
        int unsigned budget;
        int unsigned cnt;
        logic [23:0] h_exp;
        logic [31:0] n_hold;
        logic [23:0] h_hold;
        n_exp  = find_nonce(p, t, limit);
        h_exp  = model_hash(p, n_exp);
        budget = (n_exp < limit) ? 34 * (n_exp + 1) + 1 : 34 * limit;
        @(negedge clk);
        payload = p;
        target  = t;
        active  = 1'b1;
        cnt     = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (scramble && cnt == 3) begin
                payload = ~p;
                target  = 8'hFF;
            end
        end while (!terminado && cnt < budget + 5);

        if (n_exp < limit) begin
            check_eq({tag, "_latency"}, cnt, budget);
            check_eq({tag, "_nonce"}, nonceOut, n_exp);
            check_eq({tag, "_hash"}, 32'(hashOut), 32'(h_exp));
            check_eq({tag, "_h0_lt"}, 32'(hashOut[23:16] < t), 32'd1);
            check_eq({tag, "_h1_lt"}, 32'(hashOut[15:8] < t), 32'd1);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_hold_term"}, 32'(terminado), 32'd1);
            check_eq({tag, "_hold_nonce"}, nonceOut, n_exp);
        end else begin
            check_eq({tag, "_noterm"}, 32'(terminado), 32'd0);
            check_eq({tag, "_nonce_run"}, nonceOut, (cnt - 1) / 34);
        end

        n_hold = nonceOut;
        h_hold = hashOut;
        active = 1'b0;
        payload = p;
        target  = t;
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_drop_term"}, 32'(terminado), 32'd0);
        check_eq({tag, "_drop_nonce"}, nonceOut, n_hold);
        check_eq({tag, "_drop_hash"}, 32'(hashOut), 32'(h_hold));
        @(posedge clk);
    endtask

    initial begin
        int unsigned n2;
        int unsigned abort_at;
        int unsigned exp_abort_nonce;
        int unsigned bad;
        int unsigned term_seen;

        checks   = 0;
        failures = 0;

        // Reset held with active high: outputs must stay cleared
        reset_n = 1'b0;
        active  = 1'b1;
        payload = GOLD_P;
        target  = 8'hFF;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_term", 32'(terminado), 32'd0);
        check_eq("rst_nonce", nonceOut, 32'd0);
        check_eq("rst_hash", 32'(hashOut), 32'd0);
        active  = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_term", 32'(terminado), 32'd0);

        // Easy target
        run_search("easy", P3, 8'hFF, 50, 1'b0);

        // Abort mid-ROUND, then restart and expect the uninterrupted result
        n2              = find_nonce(P2, 8'h40, 400);
        abort_at        = (n2 >= 1) ? 44 : 10;
        exp_abort_nonce = (n2 >= 1) ? 1 : 0;
        @(negedge clk);
        payload = P2;
        target  = 8'h40;
        active  = 1'b1;
        repeat (abort_at) @(posedge clk);
        @(negedge clk);
        check_eq("abort_pre_term", 32'(terminado), 32'd0);
        check_eq("abort_pre_nonce", nonceOut, exp_abort_nonce);
        active = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("abort_term", 32'(terminado), 32'd0);
        check_eq("abort_nonce_hold", nonceOut, exp_abort_nonce);
        run_search("restart", P2, 8'h40, 400, 1'b0);

        // Inputs disturbed after the latch must not affect the result
        run_search("latch", P2, 8'h40, 400, 1'b1);

        // Golden vector
        run_search("gold", GOLD_P, 8'h0a, 2000, 1'b0);

        // Unreachable target: nonce steps once per 34 cycles, never terminates
        @(negedge clk);
        payload   = GOLD_P;
        target    = 8'h00;
        active    = 1'b1;
        bad       = 0;
        term_seen = 0;
        for (int unsigned c = 1; c <= 10000; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (terminado) term_seen++;
            if (nonceOut != (c - 1) / 34) bad++;
        end
        check_eq("imp_term_seen", term_seen, 32'd0);
        check_eq("imp_nonce_track", bad, 32'd0);
        check_eq("imp_nonce_final", nonceOut, 32'd294);
        active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("imp_drop_term", 32'(terminado), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
